// File: rtl/nrs_est_ctrl_if.sv
// Pilot stream, multiplier control and estimate-read signals of the NRS estimation sequencer.
// The master side is the surrounding datapath/environment; the slave side is nrs_est_ctrl.
interface nrs_est_ctrl_if #(
   parameter int WIDTH_R_I = 16,
   parameter int ADDR_W    = 2
);
   logic                 start;
   logic                 pilot_valid;
   logic                 pilot_ready;
   logic [WIDTH_R_I-1:0] rx_r_in;
   logic [WIDTH_R_I-1:0] rx_i_in;
   logic                 nrs_r_in;
   logic                 nrs_i_in;
   logic [WIDTH_R_I-1:0] rx_r;
   logic [WIDTH_R_I-1:0] rx_i;
   logic                 nrs_r;
   logic                 nrs_i;
   logic                 mult_en;
   logic [ADDR_W-1:0]    mult_wr_addr;
   logic [ADDR_W-1:0]    mult_rd_addr;
   logic                 est_valid;
   logic                 rd_req;
   logic [ADDR_W-1:0]    rd_idx;
   logic                 rd_ack;
   logic                 est_release;
   logic                 err;

   modport master (
      output start, pilot_valid, rx_r_in, rx_i_in, nrs_r_in, nrs_i_in,
             rd_req, rd_idx, est_release,
      input  pilot_ready, rx_r, rx_i, nrs_r, nrs_i, mult_en, mult_wr_addr,
             mult_rd_addr, est_valid, rd_ack, err
   );

   modport slave (
      input  start, pilot_valid, rx_r_in, rx_i_in, nrs_r_in, nrs_i_in,
             rd_req, rd_idx, est_release,
      output pilot_ready, rx_r, rx_i, nrs_r, nrs_i, mult_en, mult_wr_addr,
             mult_rd_addr, est_valid, rd_ack, err
   );
endinterface

// File: rtl/nrs_est_ctrl.sv
// Sequencer feeding NRS pilots to the channel-estimation multiplier and serving estimate reads.
// Optional COLLECT idle timeout is built when NRS_EST_TIMEOUT_EN is defined.
//
// state      | meaning
// IDLE       | waiting for start
// COLLECT    | accepting pilots; each accept schedules one multiplier write
// WRITE_LAST | final pilot's write in flight
// READY      | all estimates stored; serving indexed reads until released
module nrs_est_ctrl #(
   parameter int WIDTH_R_I  = 16,
   parameter int NUM_PILOTS = 4,
   parameter int ADDR_W     = 2
`ifdef NRS_EST_TIMEOUT_EN
  ,parameter int TIMEOUT_CYC = 64
`endif
) (
   input logic           clk,
   input logic           rst,
   nrs_est_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE_LAST, READY} state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    cnt_q, cnt_d;
   logic [WIDTH_R_I-1:0] rx_r_q, rx_r_d, rx_i_q, rx_i_d;
   logic                 nrs_r_q, nrs_r_d, nrs_i_q, nrs_i_d;
   logic                 mult_en_q, mult_en_d;
   logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
   logic                 est_valid_q, est_valid_d;
   logic                 rd_ack_q, rd_ack_d;
   logic                 pready;
   logic                 accept;

`ifdef NRS_EST_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   logic [TO_W-1:0] to_q, to_d;
   logic            err_q, err_d;
`endif

   // A restart pulse closes the pilot port so no pilot straddles two subframes.
   assign pready = (state_q == COLLECT) & ~bus.start;
   assign accept = pready & bus.pilot_valid;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rx_r_d    = rx_r_q;
      rx_i_d    = rx_i_q;
      nrs_r_d   = nrs_r_q;
      nrs_i_d   = nrs_i_q;
      mult_en_d = 1'b0;
      wr_addr_d = wr_addr_q;
      rd_addr_d = rd_addr_q;
      rd_ack_d  = 1'b0;
`ifdef NRS_EST_TIMEOUT_EN
      to_d      = '0;
      err_d     = 1'b0;
`endif
      case (state_q)
         IDLE:       state_d = IDLE;
         COLLECT: begin
            if (accept) begin
               rx_r_d    = bus.rx_r_in;
               rx_i_d    = bus.rx_i_in;
               nrs_r_d   = bus.nrs_r_in;
               nrs_i_d   = bus.nrs_i_in;
               mult_en_d = 1'b1;
               wr_addr_d = cnt_q;
               if (cnt_q == ADDR_W'(NUM_PILOTS - 1)) begin
                  cnt_d   = '0;
                  state_d = WRITE_LAST;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
`ifdef NRS_EST_TIMEOUT_EN
            else if (to_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               to_d = to_q + 1'b1;
            end
`endif
         end
         WRITE_LAST: state_d = READY;
         READY: begin
            if (bus.rd_req) begin
               rd_addr_d = bus.rd_idx;
               rd_ack_d  = 1'b1;
            end
            if (bus.est_release) state_d = IDLE;
         end
         default:    state_d = IDLE;
      endcase
      // start outranks release and restarts from any state
      if (bus.start) begin
         state_d = COLLECT;
         cnt_d   = '0;
`ifdef NRS_EST_TIMEOUT_EN
         to_d    = '0;
`endif
      end
      est_valid_d = (state_d == READY);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rx_r_q      <= '0;
         rx_i_q      <= '0;
         nrs_r_q     <= 1'b0;
         nrs_i_q     <= 1'b0;
         mult_en_q   <= 1'b0;
         wr_addr_q   <= '0;
         rd_addr_q   <= '0;
         est_valid_q <= 1'b0;
         rd_ack_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_r_q      <= rx_r_d;
         rx_i_q      <= rx_i_d;
         nrs_r_q     <= nrs_r_d;
         nrs_i_q     <= nrs_i_d;
         mult_en_q   <= mult_en_d;
         wr_addr_q   <= wr_addr_d;
         rd_addr_q   <= rd_addr_d;
         est_valid_q <= est_valid_d;
         rd_ack_q    <= rd_ack_d;
      end
   end

`ifdef NRS_EST_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_q  <= '0;
         err_q <= 1'b0;
      end else begin
         to_q  <= to_d;
         err_q <= err_d;
      end
   end
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.pilot_ready  = pready;
   assign bus.rx_r         = rx_r_q;
   assign bus.rx_i         = rx_i_q;
   assign bus.nrs_r        = nrs_r_q;
   assign bus.nrs_i        = nrs_i_q;
   assign bus.mult_en      = mult_en_q;
   assign bus.mult_wr_addr = wr_addr_q;
   assign bus.mult_rd_addr = rd_addr_q;
   assign bus.est_valid    = est_valid_q;
   assign bus.rd_ack       = rd_ack_q;

endmodule

// File: tb/tb_nrs_est_ctrl.sv
// Self-checking bench for nrs_est_ctrl: per-cycle compare against a subframe-level model,
// plus directed scenarios with hand-computed latencies, addresses and sample values.
module tb_nrs_est_ctrl;
   localparam int W  = 16;
   localparam int NP = 4;
   localparam int AW = 2;
`ifdef NRS_EST_TIMEOUT_EN
   localparam int TO = 8;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;

   nrs_est_ctrl_if #(.WIDTH_R_I(W), .ADDR_W(AW)) bus ();

   nrs_est_ctrl #(
      .WIDTH_R_I(W), .NUM_PILOTS(NP), .ADDR_W(AW)
`ifdef NRS_EST_TIMEOUT_EN
     ,.TIMEOUT_CYC(TO)
`endif
   ) dut (.clk(clk), .rst(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- subframe-level model ----------------
   bit          m_open, m_last_pend, m_ready;
   int          m_got, m_idle;
   logic [W-1:0] e_rx_r, e_rx_i;
   logic        e_nrs_r, e_nrs_i, e_men, e_rack, e_err;
   logic [AW-1:0] e_wa, e_ra;
   wire         m_acc = m_open && bus.pilot_valid && !bus.start;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_open <= 0; m_last_pend <= 0; m_ready <= 0; m_got <= 0; m_idle <= 0;
         e_rx_r <= '0; e_rx_i <= '0; e_nrs_r <= 0; e_nrs_i <= 0;
         e_men <= 0; e_rack <= 0; e_err <= 0; e_wa <= '0; e_ra <= '0;
      end else begin
         e_men  <= m_acc;
         e_rack <= m_ready && bus.rd_req;
         if (m_acc) begin
            e_wa    <= AW'(m_got);
            e_rx_r  <= bus.rx_r_in;
            e_rx_i  <= bus.rx_i_in;
            e_nrs_r <= bus.nrs_r_in;
            e_nrs_i <= bus.nrs_i_in;
         end
         if (m_ready && bus.rd_req) e_ra <= bus.rd_idx;
         e_err <= 1'b0;
`ifdef NRS_EST_TIMEOUT_EN
         if (m_open && !m_acc && m_idle == TO - 1) e_err <= 1'b1;
`endif
         if (bus.start) begin
            m_open <= 1; m_got <= 0; m_last_pend <= 0; m_ready <= 0; m_idle <= 0;
         end else begin
            if (m_acc) begin
               m_got <= m_got + 1;
               if (m_got + 1 == NP) begin m_open <= 0; m_last_pend <= 1; end
            end
            if (m_last_pend) begin m_last_pend <= 0; m_ready <= 1; end
            if (m_ready && bus.est_release) m_ready <= 0;
`ifdef NRS_EST_TIMEOUT_EN
            if (!m_open || m_acc) m_idle <= 0;
            else if (m_idle == TO - 1) begin m_idle <= 0; m_open <= 0; end
            else m_idle <= m_idle + 1;
`endif
         end
      end
   end

   always @(negedge clk) begin
      chk("pilot_ready", bus.pilot_ready, m_open && !bus.start);
      chk("rx_r", bus.rx_r, e_rx_r);
      chk("rx_i", bus.rx_i, e_rx_i);
      chk("nrs_r", bus.nrs_r, e_nrs_r);
      chk("nrs_i", bus.nrs_i, e_nrs_i);
      chk("mult_en", bus.mult_en, e_men);
      chk("mult_wr_addr", bus.mult_wr_addr, e_wa);
      chk("mult_rd_addr", bus.mult_rd_addr, e_ra);
      chk("est_valid", bus.est_valid, m_ready);
      chk("rd_ack", bus.rd_ack, e_rack);
      chk("err", bus.err, e_err);
   end

   // ---------------- event monitors ----------------
   int wq_cyc[$], wq_addr[$], wq_rx[$], wq_sgn[$];
   int aq_cyc[$], aq_addr[$];

   always @(negedge clk) begin
      if (bus.mult_en) begin
         wq_cyc.push_back(cyc);
         wq_addr.push_back(int'(bus.mult_wr_addr));
         wq_rx.push_back(int'(bus.rx_r));
         wq_sgn.push_back(int'({bus.nrs_r, bus.nrs_i}));
      end
      if (bus.rd_ack) begin
         aq_cyc.push_back(cyc);
         aq_addr.push_back(int'(bus.mult_rd_addr));
      end
   end

   task automatic clear_q();
      wq_cyc.delete(); wq_addr.delete(); wq_rx.delete(); wq_sgn.delete();
      aq_cyc.delete(); aq_addr.delete();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pilot(input int d, input int sgn);
      bus.pilot_valid = 1'b1;
      bus.rx_r_in     = W'(d);
      bus.rx_i_in     = W'(d + 'h1000);
      bus.nrs_r_in    = sgn[1];
      bus.nrs_i_in    = sgn[0];
   endtask

   task automatic wait_est(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.est_valid) begin at = cyc; break; end
      end
      chk("est_valid_seen", at >= 0, 1);
   endtask

   initial begin
      int t0, te;
      int exp_rs[6];
      bus.start = 0; bus.pilot_valid = 0; bus.rx_r_in = '0; bus.rx_i_in = '0;
      bus.nrs_r_in = 0; bus.nrs_i_in = 0; bus.rd_req = 0; bus.rd_idx = '0;
      bus.est_release = 0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_pilot_ready", bus.pilot_ready, 0);
      chk("reset_mult_en", bus.mult_en, 0);
      chk("reset_est_valid", bus.est_valid, 0);
      chk("reset_rx_r", bus.rx_r, 0);
      step(); rst_n = 1'b1;

      // back-to-back pilots
      step(); clear_q(); bus.start = 1; t0 = cyc;
      step(); bus.start = 0;
      for (int i = 0; i < NP; i++) begin pilot('h100 + i, i); step(); end
      bus.pilot_valid = 0;
      wait_est(20, te);
      chk("b2b_start_to_valid", te - t0, NP + 2);
      chk("b2b_nwrites", wq_addr.size(), NP);
      if (wq_addr.size() == NP)
         for (int i = 0; i < NP; i++) begin
            chk("b2b_addr", wq_addr[i], i);
            chk("b2b_write_cycle", wq_cyc[i], t0 + 2 + i);
            chk("b2b_rx_r", wq_rx[i], 'h100 + i);
            chk("b2b_signs", wq_sgn[i], i);
         end

      // reads 3,0,2 back-to-back, pilots ignored in READY
      step(); bus.rd_req = 1; bus.rd_idx = 2'd3;
      step(); bus.rd_idx = 2'd0;
      step(); bus.rd_idx = 2'd2;
      step(); bus.rd_req = 0; pilot('h7777, 3);
      step(); step(); bus.pilot_valid = 0;
      chk("rd_nacks", aq_addr.size(), 3);
      if (aq_addr.size() == 3) begin
         chk("rd_addr0", aq_addr[0], 3);
         chk("rd_addr1", aq_addr[1], 0);
         chk("rd_addr2", aq_addr[2], 2);
         chk("rd_ack_contig", aq_cyc[2] - aq_cyc[0], 2);
      end
      chk("ready_no_write", wq_addr.size(), NP);
      bus.est_release = 1;
      step(); bus.est_release = 0;
      @(negedge clk);
      chk("release_est_valid", bus.est_valid, 0);
      step(); bus.rd_req = 1; bus.rd_idx = 2'd1;
      step(); bus.rd_req = 0;
      step(); @(negedge clk);
      chk("idle_rd_no_ack", aq_addr.size(), 3);

      // gapped pilots, one every third cycle
      step(); clear_q(); bus.start = 1;
      step(); bus.start = 0;
      for (int i = 0; i < NP; i++) begin
         pilot('h200 + 17 * i, 3 - i); step(); bus.pilot_valid = 0; step(); step();
      end
      wait_est(20, te);
      chk("gap_nwrites", wq_addr.size(), NP);
      if (wq_addr.size() == NP)
         for (int i = 0; i < NP; i++) begin
            chk("gap_addr", wq_addr[i], i);
            chk("gap_rx_r", wq_rx[i], 'h200 + 17 * i);
            chk("gap_signs", wq_sgn[i], 3 - i);
            if (i > 0) chk("gap_spacing", wq_cyc[i] - wq_cyc[i-1], 3);
         end

      // restart after two pilots (issued from READY)
      step(); clear_q(); bus.start = 1;
      step(); bus.start = 0;
      pilot('h300, 0); step(); pilot('h301, 1); step();
      bus.pilot_valid = 0; bus.start = 1; t0 = cyc;
      step(); bus.start = 0;
      for (int i = 0; i < NP; i++) begin pilot('h400 + i, 2); step(); end
      bus.pilot_valid = 0;
      wait_est(20, te);
      chk("restart_start_to_valid", te - t0, NP + 2);
      exp_rs = '{0, 1, 0, 1, 2, 3};
      chk("restart_nwrites", wq_addr.size(), 6);
      if (wq_addr.size() == 6)
         for (int i = 0; i < 6; i++) chk("restart_addr", wq_addr[i], exp_rs[i]);

      // reset in the middle of COLLECT
      step(); bus.start = 1;
      step(); bus.start = 0;
      pilot('h500, 1); step(); pilot('h501, 2); step(); pilot('h502, 3);
      rst_n = 1'b0; #1;
      chk("midrst_mult_en", bus.mult_en, 0);
      chk("midrst_pilot_ready", bus.pilot_ready, 0);
      chk("midrst_rx_r", bus.rx_r, 0);
      chk("midrst_wr_addr", bus.mult_wr_addr, 0);
      clear_q();
      repeat (3) step();
      rst_n = 1'b1;
      repeat (4) step();
      bus.pilot_valid = 0;
      @(negedge clk);
      chk("postrst_no_write", wq_addr.size(), 0);
      chk("postrst_est_valid", bus.est_valid, 0);

`ifdef NRS_EST_TIMEOUT_EN
      begin
         int ta, terr;
         step(); clear_q(); bus.start = 1;
         step(); bus.start = 0; pilot('h600, 1); ta = cyc + 1;
         step(); bus.pilot_valid = 0;
         terr = -1;
         for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.err) begin terr = cyc; break; end
         end
         chk("timeout_err_seen", terr >= 0, 1);
         chk("timeout_latency", terr - ta, TO);
         @(negedge clk);
         chk("timeout_idle", bus.pilot_ready, 0);
         chk("timeout_no_valid", bus.est_valid, 0);
      end
`endif

      step(); step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule

// File: doc/nrs_est_ctrl.md
# nrs_est_ctrl

- Sequencer for the NRS channel-estimation complex multiplier.
- Accepts a stream of received NRS pilot samples and their pilot sign bits through a valid/ready handshake.
- Feeds each pilot to the multiplier one per cycle and generates its write enable and slot address.
- Once all NUM_PILOTS estimates of a subframe are stored, serves indexed read requests from the downstream interpolator until the estimates are released.

## Interface

Parameters:
- WIDTH_R_I, 16, width of each rx real/imag sample
- NUM_PILOTS, 4, estimates per subframe (equals multiplier storage depth)
- ADDR_W, 2, slot address width, clog2(NUM_PILOTS)
- TIMEOUT_CYC, 64, max idle cycles between pilots in COLLECT (used only with NRS_EST_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin a new subframe collection
- pilot_valid  in  1  pilot sample/sign present
- pilot_ready  out  1  controller accepts pilot this cycle
- rx_r_in, rx_i_in  in  WIDTH_R_I each  received pilot sample
- nrs_r_in, nrs_i_in  in  1 each  pilot sign bits (1 = negative)
- rx_r, rx_i  out  WIDTH_R_I each  registered sample to multiplier
- nrs_r, nrs_i  out  1 each  registered signs to multiplier
- mult_en  out  1  multiplier write enable
- mult_wr_addr  out  ADDR_W  multiplier write slot
- mult_rd_addr  out  ADDR_W  multiplier read slot
- est_valid  out  1  all estimates stored and readable
- rd_req  in  1  downstream read request
- rd_idx  in  ADDR_W  requested slot
- rd_ack  out  1  multiplier read data valid for the slot last requested
- est_release  in  1  one-cycle pulse: estimates consumed
- err  out  1  one-cycle timeout pulse (only with NRS_EST_TIMEOUT_EN; otherwise tied 0)

## Operation

States:
- IDLE
  - pilot_ready=0.
  - start → COLLECT, cnt=0.
- COLLECT
  - pilot_ready=1.
  - Each accepted pilot (pilot_valid & pilot_ready) is registered into rx_r/rx_i/nrs_r/nrs_i.
  - On the next cycle: mult_en=1, mult_wr_addr=cnt; cnt increments.
  - Accepting pilot NUM_PILOTS-1 → WRITE_LAST (pilot_ready=0).
- WRITE_LAST
  - Issues the final write → READY.
- READY
  - est_valid=1.
  - rd_req registers rd_idx into mult_rd_addr; rd_ack=1 the following cycle.
  - Back-to-back rd_req allowed; one ack per request, in order.
  - est_release → IDLE.

Boundary rules:
- start in any non-IDLE state restarts collection:
  - cnt=0, est_valid drops next cycle, state → COLLECT.
  - A write already scheduled for that cycle still completes.
- start and est_release in the same cycle: start wins.
- pilot_valid outside COLLECT is ignored; nothing is written.
- rd_req outside READY is ignored; no rd_ack.
- rd_idx ≥ NUM_PILOTS: address wraps modulo 2^ADDR_W.
- Reset at any point → IDLE; in-flight write is lost.
- Sign bits are passed unmodified; the controller never alters sample data.

## Timing

- Reset values: pilot_ready=0, rx_r=rx_i=0, nrs_r=nrs_i=0, mult_en=0, mult_wr_addr=0, mult_rd_addr=0, est_valid=0, rd_ack=0, err=0, cnt=0, state=IDLE.
- pilot_ready goes high the cycle after start.
- Accept at edge N → mult_en/addr high during cycle N+1 → multiplier stores at edge N+2.
- Full-rate stream: 1 pilot/cycle.
- est_valid rises the cycle after the last mult_en cycle. Minimum start-to-est_valid = NUM_PILOTS+2 cycles.
- Read latency: rd_req at edge N → rd_ack during cycle N+1, multiplier output valid in that same cycle.
- mult_en is never asserted in IDLE or READY.

## Configuration

- NRS_EST_TIMEOUT_EN defined:
  - A counter runs in COLLECT, cleared on every accepted pilot.
  - On reaching TIMEOUT_CYC with no accept: err pulses 1 cycle and state → IDLE.
  - Partial estimates are not flagged valid.
- Undefined: no counter is built, err is constant 0, and COLLECT waits indefinitely.

## Test plan

- Reset, start, 4 back-to-back pilots (rx_r=0x0100..0x0103, signs 00,01,10,11) → mult_en high 4 consecutive cycles with wr_addr 0,1,2,3; est_valid high exactly NUM_PILOTS+2 cycles after start.
- Gapped pilots (valid every 3rd cycle) → 4 writes at addresses 0..3 with correct registered samples; no mult_en between pilots.
- In READY, rd_req with rd_idx 3,0,2 back-to-back → mult_rd_addr 3,0,2 and rd_ack high 3 consecutive cycles; est_release → IDLE, est_valid=0 next cycle.
- start after 2 pilots → cnt restarts; next pilot writes addr 0; est_valid only after 4 further pilots.
- rst asserted mid-COLLECT → all outputs return to reset values immediately; pilot_valid during reset ignored.
- With NRS_EST_TIMEOUT_EN and TIMEOUT_CYC=8: 1 pilot then silence → err pulse 8 cycles after the accept, state IDLE, est_valid never asserts.
